// File: rtl/jtroadf_pcm_fetch.sv
// ROM-fed PCM sample player: prefetches unsigned bytes from a shared ROM slot
// into a small FIFO and plays one signed sample per sample-rate enable.
module jtroadf_pcm_fetch #(
  parameter int AW = 16,
  parameter int FD = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          smp_cen,
  input  logic          play,
  input  logic          stop,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] end_addr,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok,
  output logic [7:0]    snd,
  output logic          busy,
  output logic          done,
  output logic          underrun
);

  localparam int          DEPTH    = 2 ** FD;
  localparam logic [FD:0] CNT_FULL = (FD + 1)'(DEPTH);
  localparam logic [FD:0] CNT_LAST = (FD + 1)'(DEPTH - 1);
  localparam logic [FD:0] CNT_ONE  = (FD + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT,
    ST_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] end_q, end_d;
  logic          fetch_q, fetch_d;
  logic          cs_q, cs_d;
  logic [FD-1:0] wr_ptr_q, wr_ptr_d;
  logic [FD-1:0] rd_ptr_q, rd_ptr_d;
  logic [FD:0]   cnt_q, cnt_d;
  logic [7:0]    snd_q, snd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          underrun_q, underrun_d;
  logic          push, pop;
  logic [7:0]    mem [DEPTH];

  always_comb begin
    // NOTE: every signal gets its default first so no path can infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    end_d      = end_q;
    fetch_d    = fetch_q;
    cs_d       = cs_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    snd_d      = snd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    underrun_d = underrun_q;
    push       = 1'b0;
    pop        = 1'b0;

    if (play) begin
      state_d    = ST_SETUP;
      addr_d     = start_addr;
      end_d      = end_addr;
      fetch_d    = 1'b1;
      cs_d       = 1'b1;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      busy_d     = 1'b1;
      underrun_d = 1'b0;
    end else if (stop) begin
      state_d  = ST_IDLE;
      fetch_d  = 1'b0;
      cs_d     = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      snd_d    = 8'h00;
      busy_d   = 1'b0;
    end else begin
      pop = smp_cen && busy_q && (cnt_q != '0);

      case (state_q)
        ST_IDLE:  cs_d = 1'b0;
        // rom_ok may still refer to the previous address here, so skip it.
        ST_SETUP: begin
          state_d = ST_WAIT;
          cs_d    = 1'b1;
        end
        ST_WAIT: begin
          if (rom_ok) begin
            push = 1'b1;
            if (addr_q == end_q) begin
              state_d = ST_IDLE;
              cs_d    = 1'b0;
              fetch_d = 1'b0;
            end else begin
              addr_d = addr_q + 1'b1;
              if (pop || cnt_q < CNT_LAST) begin
                state_d = ST_SETUP;
                cs_d    = 1'b1;
              end else begin
                state_d = ST_HOLD;
                cs_d    = 1'b0;
              end
            end
          end
        end
        ST_HOLD: begin
          if (cnt_q != CNT_FULL) begin
            state_d = ST_SETUP;
            cs_d    = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase

      if (smp_cen && busy_q) begin
        if (cnt_q != '0) begin
          snd_d = mem[rd_ptr_q] ^ 8'h80;
        end else if (fetch_q) begin
          underrun_d = 1'b1;
        end else begin
          snd_d  = 8'h00;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      end_q      <= '0;
      fetch_q    <= 1'b0;
      cs_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      snd_q      <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      end_q      <= end_d;
      fetch_q    <= fetch_d;
      cs_q       <= cs_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      snd_q      <= snd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  // NOTE: FIFO storage is not reset; the occupancy counter alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= rom_data;
  end

  assign rom_addr = addr_q;
  assign rom_cs   = cs_q;
  assign snd      = snd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_jtroadf_pcm_fetch.sv
// Directed bench for jtroadf_pcm_fetch with a behavioural ROM of programmable
// latency and a log of every distinct ROM request.
module tb_jtroadf_pcm_fetch;

  logic        clk = 1'b0;
  logic        rst, smp_cen, play, stop;
  logic [15:0] start_addr, end_addr, rom_addr;
  logic        rom_cs, rom_ok;
  logic [7:0]  rom_data, snd;
  logic        busy, done, underrun;

  int vectors = 0;
  int errors  = 0;
  int lat     = 3;
  bit perm    = 1'b0;
  int done_cnt = 0;
  int age = 0;
  logic        prev_cs = 1'b0;
  logic [15:0] last_addr = '0;
  logic [15:0] req_log[$];

  jtroadf_pcm_fetch #(.AW(16), .FD(2)) dut (
    .clk(clk), .rst(rst), .smp_cen(smp_cen), .play(play), .stop(stop),
    .start_addr(start_addr), .end_addr(end_addr), .rom_addr(rom_addr),
    .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok), .snd(snd),
    .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    case (a)
      16'h0100: return 8'h80;
      16'h0101: return 8'hFF;
      16'h0102: return 8'h00;
      16'h0103: return 8'h7F;
      default:  return a[7:0] + a[15:8] + 8'h35;
    endcase
  endfunction

  // ROM answers `lat` cycles after an address is first requested, or always in perm mode.
  always @(negedge clk) begin
    if (rom_cs && prev_cs && rom_addr == last_addr) age++;
    else age = 0;
    if (rom_cs && (!prev_cs || rom_addr != last_addr)) req_log.push_back(rom_addr);
    prev_cs   = rom_cs;
    last_addr = rom_addr;
    rom_ok    = perm || (rom_cs && age >= lat);
    rom_data  = rom_byte(rom_addr);
    if (done === 1'b1) done_cnt++;
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_smp();
    smp_cen = 1'b1;
    cyc();
    smp_cen = 1'b0;
  endtask

  task automatic do_play(input logic [15:0] s, input logic [15:0] e);
    start_addr = s;
    end_addr   = e;
    play = 1'b1;
    cyc();
    play = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; smp_cen = 1'b0; play = 1'b0; stop = 1'b0;
    start_addr = '0; end_addr = '0;
    cyc(3);
    rst = 1'b0;
    vectors++; if (rom_addr !== 16'h0000) begin errors++; $display("FAIL reset_rom_addr: got %h want 0000", rom_addr); end
    vectors++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL reset_rom_cs: got %b want 0", rom_cs); end
    vectors++; if (snd !== 8'h00) begin errors++; $display("FAIL reset_snd: got %h want 00", snd); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_basic();
    logic [7:0] exp_s [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};
    int dc0 = done_cnt;
    lat = 3;
    req_log.delete();
    do_play(16'h0100, 16'h0103);
    vectors++; if (rom_cs !== 1'b1 || rom_addr !== 16'h0100) begin errors++; $display("FAIL basic_first_req: got cs=%b addr=%h want cs=1 addr=0100", rom_cs, rom_addr); end
    for (int i = 0; i < 4; i++) begin
      cyc(19);
      pulse_smp();
      vectors++; if (snd !== exp_s[i]) begin errors++; $display("FAIL basic_snd[%0d]: got %h want %h", i, snd, exp_s[i]); end
      vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy[%0d]: got %b want 1", i, busy); end
    end
    cyc(19);
    pulse_smp();
    vectors++; if (snd !== 8'h00 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_end: got snd=%h done=%b busy=%b want 00/1/0", snd, done, busy); end
    cyc();
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b want 0", done); end
    vectors++; if (done_cnt - dc0 !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - dc0); end
    vectors++; if (underrun !== 1'b0) begin errors++; $display("FAIL basic_underrun: got %b want 0", underrun); end
    vectors++; if (req_log.size() !== 4) begin errors++; $display("FAIL basic_req_count: got %0d want 4", req_log.size()); end
  endtask

  task automatic test_underrun();
    logic [7:0] exp_s [5] = '{8'h00, 8'h7F, 8'h80, 8'hFF, 8'h00};
    logic [7:0] got[$];
    logic [7:0] prev;
    int guard = 0;
    int dc0 = done_cnt;
    lat = 10;
    do_play(16'h0100, 16'h0103);
    prev = snd;
    got.push_back(prev);
    while (busy === 1'b1 && guard < 200) begin
      cyc();
      pulse_smp();
      guard++;
      if (snd !== prev) begin
        got.push_back(snd);
        prev = snd;
      end
    end
    vectors++; if (guard >= 200) begin errors++; $display("FAIL underrun_timeout: got %0d enables want <200", guard); end
    vectors++; if (got.size() !== 5) begin errors++; $display("FAIL underrun_seq_len: got %0d want 5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      vectors++; if (got[i] !== exp_s[i]) begin errors++; $display("FAIL underrun_seq[%0d]: got %h want %h", i, got[i], exp_s[i]); end
    end
    vectors++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_flag: got %b want 1", underrun); end
    cyc();
    vectors++; if (done_cnt - dc0 !== 1) begin errors++; $display("FAIL underrun_done_count: got %0d want 1", done_cnt - dc0); end
  endtask

  task automatic test_hold();
    int g = 0;
    perm = 1'b1;
    req_log.delete();
    do_play(16'h0200, 16'h0209);
    vectors++; if (underrun !== 1'b0) begin errors++; $display("FAIL hold_underrun_clear: got %b want 0", underrun); end
    cyc(20);
    vectors++; if (req_log.size() !== 4) begin errors++; $display("FAIL hold_req_count: got %0d want 4", req_log.size()); end
    vectors++; if (rom_cs !== 1'b0 || rom_addr !== 16'h0204) begin errors++; $display("FAIL hold_state: got cs=%b addr=%h want cs=0 addr=0204", rom_cs, rom_addr); end
    pulse_smp();
    vectors++; if (snd !== 8'hB7) begin errors++; $display("FAIL hold_snd[0]: got %h want b7", snd); end
    while (rom_cs !== 1'b1 && g < 6) begin cyc(); g++; end
    vectors++; if (rom_cs !== 1'b1 || rom_addr !== 16'h0204) begin errors++; $display("FAIL hold_resume: got cs=%b addr=%h want cs=1 addr=0204", rom_cs, rom_addr); end
    for (int i = 1; i < 10; i++) begin
      cyc(19);
      pulse_smp();
      vectors++; if (snd !== ((8'h37 + 8'(i)) ^ 8'h80)) begin errors++; $display("FAIL hold_snd[%0d]: got %h want %h", i, snd, (8'h37 + 8'(i)) ^ 8'h80); end
    end
    cyc(19);
    pulse_smp();
    vectors++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL hold_end: got done=%b busy=%b want 1/0", done, busy); end
    vectors++; if (req_log.size() !== 10) begin errors++; $display("FAIL hold_req_total: got %0d want 10", req_log.size()); end
    perm = 1'b0;
    cyc();
  endtask

  task automatic test_stop();
    int g = 0;
    int dc0 = done_cnt;
    lat = 8;
    do_play(16'h0100, 16'h0103);
    while (!(rom_cs === 1'b1 && rom_addr === 16'h0101) && g < 40) begin cyc(); g++; end
    pulse_smp();
    vectors++; if (snd !== 8'h00) begin errors++; $display("FAIL stop_snd0: got %h want 00", snd); end
    while (!(rom_cs === 1'b1 && rom_addr === 16'h0102) && g < 40) begin cyc(); g++; end
    vectors++; if (g >= 40) begin errors++; $display("FAIL stop_reach_0102: got %0d cycles want <40", g); end
    pulse_smp();
    vectors++; if (snd !== 8'h7F) begin errors++; $display("FAIL stop_snd1: got %h want 7f", snd); end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    vectors++; if (rom_cs !== 1'b0 || busy !== 1'b0 || snd !== 8'h00 || done !== 1'b0) begin errors++; $display("FAIL stop_outputs: got cs=%b busy=%b snd=%h done=%b want 0/0/00/0", rom_cs, busy, snd, done); end
    cyc(30);
    vectors++; if (done_cnt !== dc0 || rom_cs !== 1'b0) begin errors++; $display("FAIL stop_quiet: got done_pulses=%0d cs=%b want 0/0", done_cnt - dc0, rom_cs); end
    lat = 3;
    req_log.delete();
    do_play(16'h2000, 16'h2001);
    vectors++; if (rom_cs !== 1'b1 || rom_addr !== 16'h2000) begin errors++; $display("FAIL stop_replay_req: got cs=%b addr=%h want 1/2000", rom_cs, rom_addr); end
    cyc(19); pulse_smp();
    vectors++; if (snd !== 8'hD5) begin errors++; $display("FAIL stop_replay_snd0: got %h want d5", snd); end
    cyc(19); pulse_smp();
    vectors++; if (snd !== 8'hD6) begin errors++; $display("FAIL stop_replay_snd1: got %h want d6", snd); end
    cyc(19); pulse_smp();
    vectors++; if (done !== 1'b1) begin errors++; $display("FAIL stop_replay_done: got %b want 1", done); end
    vectors++; if (req_log.size() < 1 || req_log[0] !== 16'h2000) begin errors++; $display("FAIL stop_replay_first: got %0d entries want first 2000", req_log.size()); end
    cyc();
  endtask

  task automatic test_wrap();
    logic [15:0] exp_a [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    logic [7:0]  exp_s [4] = '{8'hB2, 8'hB3, 8'hB5, 8'hB6};
    lat = 2;
    req_log.delete();
    do_play(16'hFFFE, 16'h0001);
    for (int i = 0; i < 4; i++) begin
      cyc(19);
      pulse_smp();
      vectors++; if (snd !== exp_s[i]) begin errors++; $display("FAIL wrap_snd[%0d]: got %h want %h", i, snd, exp_s[i]); end
    end
    cyc(19);
    pulse_smp();
    vectors++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL wrap_end: got done=%b busy=%b want 1/0", done, busy); end
    vectors++; if (req_log.size() !== 4) begin errors++; $display("FAIL wrap_req_count: got %0d want 4", req_log.size()); end
    for (int i = 0; i < 4 && i < req_log.size(); i++) begin
      vectors++; if (req_log[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_req[%0d]: got %h want %h", i, req_log[i], exp_a[i]); end
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_s [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};
    lat = 3;
    do_play(16'h0100, 16'h0103);
    cyc(19);
    pulse_smp();
    pulse_smp();
    vectors++; if (snd !== 8'h7F) begin errors++; $display("FAIL rstmid_pre: got %h want 7f", snd); end
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    vectors++; if (rom_cs !== 1'b0 || rom_addr !== 16'h0000 || snd !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || underrun !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs: got cs=%b addr=%h snd=%h busy=%b done=%b ur=%b want all 0", rom_cs, rom_addr, snd, busy, done, underrun);
    end
    do_play(16'h0100, 16'h0103);
    vectors++; if (rom_addr !== 16'h0100 || rom_cs !== 1'b1) begin errors++; $display("FAIL rstmid_replay_req: got cs=%b addr=%h want 1/0100", rom_cs, rom_addr); end
    for (int i = 0; i < 4; i++) begin
      cyc(19);
      pulse_smp();
      vectors++; if (snd !== exp_s[i]) begin errors++; $display("FAIL rstmid_snd[%0d]: got %h want %h", i, snd, exp_s[i]); end
    end
    cyc(19);
    pulse_smp();
    vectors++; if (done !== 1'b1) begin errors++; $display("FAIL rstmid_done: got %b want 1", done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_hold();
    test_stop();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/jtroadf_pcm_fetch.md
Name: jtroadf_pcm_fetch

Overview:
- ROM-fed PCM sample player for the sound subsystem.
- Receives a start/end byte range from the sound CPU and prefetches unsigned 8-bit samples through a shared SDRAM ROM slot into a small FIFO.
- Plays one sample per sample-rate enable, converted to signed.
- Sits between the sound CPU register decode (upstream) and the sound mixer (downstream); its ROM side connects to the PCM slot of the ROM arbiter.

Parameters:
- AW, 16, PCM ROM byte-address width.
- FD, 2, log2 of FIFO depth (depth = 2**FD = 4 entries).

Ports:
- clk  in  1  system clock (24 MHz domain).
- rst  in  1  synchronous reset, active high.
- smp_cen  in  1  sample-rate clock enable, one-cycle pulse.
- play  in  1  one-cycle pulse: latch start_addr/end_addr and begin playback.
- stop  in  1  one-cycle pulse: abort playback.
- start_addr  in  AW  first sample byte address.
- end_addr  in  AW  last sample byte address (inclusive).
- rom_addr  out  AW  ROM byte address.
- rom_cs  out  1  ROM request.
- rom_data  in  8  ROM byte.
- rom_ok  in  1  ROM data valid for the current rom_addr while rom_cs is high.
- snd  out  8  signed sample.
- busy  out  1  high from play until the last sample has been output.
- done  out  1  one-cycle pulse when playback completes normally.
- underrun  out  1  sticky flag; cleared by play or rst.

Behaviour:
- Reset (synchronous):
  - FSM enters IDLE.
  - rom_addr=0, rom_cs=0, snd=0, busy=0, done=0, underrun=0.
  - FIFO emptied; fetch pointer and end register cleared.
- Fetch FSM states: IDLE, SETUP, WAIT, HOLD.
  - IDLE: rom_cs=0. On play → SETUP, with rom_addr=start_addr, end register=end_addr, FIFO flushed, underrun cleared, busy=1.
  - SETUP: one guard cycle with rom_cs=1 after every address change. rom_ok is ignored in this cycle because it may be stale from the previous address. Next state is WAIT.
  - WAIT: rom_cs=1. When rom_ok=1, push rom_data into the FIFO.
    - If rom_addr==end register → IDLE-fetch-finished (rom_cs=0, fetch flag cleared).
    - Else rom_addr+=1 (AW-bit wrap allowed), then go to SETUP if the FIFO has room after the push, or HOLD if it is full.
  - HOLD: rom_cs=0. Go to SETUP when the FIFO is no longer full.
- If end_addr<start_addr, fetching wraps through 2**AW until rom_addr equals end_addr. This is defined behaviour.
- Playback:
  - On smp_cen with busy=1 and FIFO not empty: pop, snd = rom_data^8'h80 (unsigned→signed), registered one cycle after smp_cen.
  - On smp_cen with busy=1, FIFO empty and fetch still active: snd holds its last value, underrun=1.
  - On smp_cen with busy=1, FIFO empty and fetch finished: snd=0, busy=0, done=1 for exactly one cycle.
- Simultaneous events:
  - A push and a pop in the same cycle are both honoured; FIFO occupancy is unchanged.
  - play while busy restarts playback: FIFO flushed, new range latched, state SETUP. Any rom_ok in that cycle is discarded. No done pulse.
  - stop (in any state) → IDLE, rom_cs=0, FIFO flushed, snd=0, busy=0, no done.
  - play and stop in the same cycle: play wins.
- Latency:
  - First ROM request 1 cycle after play.
  - First push no earlier than 2 cycles after play.
  - snd updates 1 cycle after the qualifying smp_cen.
- FIFO: occupancy counter FD+1 bits wide. No pop when empty, no push when full; the FSM guarantees no push is attempted when full.

Test Plan:
- rst held 3 cycles mid-playback → all outputs 0, rom_cs=0, FIFO empty, and the next play starts cleanly from start_addr.
- play start=0x0100, end=0x0103, ROM bytes 80,FF,00,7F, rom_ok after 3 cycles, smp_cen every 20 cycles → snd sequence 00,7F,80,FF then 0. done pulses once. busy spans all four samples. underrun=0.
- Same range, smp_cen every 2 cycles, rom_ok delayed 10 cycles → underrun=1, snd holds its previous value on starved enables, and all 4 samples are eventually output in order.
- rom_ok held permanently high with smp_cen slow → exactly one push per address (no double pushes from stale ok). FIFO stops at 4 entries, rom_cs=0 in HOLD, and fetch resumes after the first pop.
- stop issued during WAIT at rom_addr=0x0102 → next cycle rom_cs=0, busy=0, snd=0, no done. A later play at 0x2000 fetches 0x2000 first.
- play start=0xFFFE, end=0x0001 → addresses FFFE,FFFF,0000,0001 requested in order and 4 samples output.
